commit_trace_fifo: RTL and testbench

- Downstream consumer of the pipeline core's commit outputs: retired-instruction PC, instruction, writeback register address and data, and the memory-stage stall flag.
- Captures one trace record per retiring instruction into a circular buffer.
- Drains the records through a valid/ready interface to a debug/UART sink.
- Tags each record with a sequence number and counts records dropped on overflow, so software can detect gaps.

---
 rtl/commit_trace_fifo.sv | 140 ++++++++++++++
 tb/tb_commit_trace_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures retired-instruction records into a circular buffer and drains them over valid/ready.
// Optional macro TRACE_FILTER_NOP_EN suppresses capture of canonical NOPs and bubbles.
module commit_trace_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic                     stall_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [XLEN-1:0]          trace_instr_o,
  output logic [4:0]               trace_rd_addr_o,
  output logic [XLEN-1:0]          trace_rd_data_o,
  output logic [SEQ_W-1:0]         trace_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [SEQ_W-1:0]         drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [4:0]       rd_mem    [DEPTH];
  logic [XLEN-1:0]  data_mem  [DEPTH];
  logic [SEQ_W-1:0] seq_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [SEQ_W-1:0] seq;
  logic [SEQ_W-1:0] drop_cnt;
  logic             overflow;
  logic             commit;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             head_hit;

  always_comb begin
    commit = enable_i & ~stall_i;
`ifdef TRACE_FILTER_NOP_EN
    commit = commit & (instr_i != XLEN'('h13)) & (instr_i != '0);
`endif
    full     = (count == CNT_W'(DEPTH));
    pop      = trace_valid_o & trace_ready_i;
    push     = commit & (~full | pop);
    drop     = commit & full & ~pop;
    rd_next  = rd_ptr + PTR_W'(pop);
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
    // The next head slot is being written this cycle (push into empty, or push+pop at count 1)
    head_hit = push & (wr_ptr == rd_next);
  end

  always_ff @(posedge clk_i) begin
    if (rstn_i && push) begin
      pc_mem[wr_ptr]    <= pc_i;
      instr_mem[wr_ptr] <= instr_i;
      rd_mem[wr_ptr]    <= reg_addr_i;
      data_mem[wr_ptr]  <= reg_data_i;
      seq_mem[wr_ptr]   <= seq;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      seq             <= '0;
      overflow        <= 1'b0;
      drop_cnt        <= '0;
      trace_pc_o      <= '0;
      trace_instr_o   <= '0;
      trace_rd_addr_o <= '0;
      trace_rd_data_o <= '0;
      trace_seq_o     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      // Dropped commits still consume a sequence number so the gap is visible downstream
      if (commit) begin
        seq <= seq + SEQ_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (clear_i) begin
          drop_cnt <= SEQ_W'(1);
        end else if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + SEQ_W'(1);
        end
      end else if (clear_i) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
      if (count_next != '0) begin
        if (head_hit) begin
          trace_pc_o      <= pc_i;
          trace_instr_o   <= instr_i;
          trace_rd_addr_o <= reg_addr_i;
          trace_rd_data_o <= reg_data_i;
          trace_seq_o     <= seq;
        end else begin
          trace_pc_o      <= pc_mem[rd_next];
          trace_instr_o   <= instr_mem[rd_next];
          trace_rd_addr_o <= rd_mem[rd_next];
          trace_rd_data_o <= data_mem[rd_next];
          trace_seq_o     <= seq_mem[rd_next];
        end
      end
    end
  end

  assign trace_valid_o = (count != '0);
  assign count_o       = count;
  assign overflow_o    = overflow;
  assign drop_cnt_o    = drop_cnt;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Scoreboard bench for commit_trace_fifo: stimulus pushes expected records, a negedge monitor checks each drained record.
module tb_commit_trace_fifo;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        enable_i;
  logic        clear_i;
  logic        stall_i;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic [4:0]  reg_addr_i;
  logic [31:0] reg_data_i;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_instr_o;
  logic [4:0]  trace_rd_addr_o;
  logic [31:0] trace_rd_data_o;
  logic [15:0] trace_seq_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] seq_model = '0;
  logic [116:0] sb [$];

  commit_trace_fifo #(.XLEN(32), .DEPTH(16), .SEQ_W(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i), .clear_i(clear_i),
    .stall_i(stall_i), .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i),
    .reg_data_i(reg_data_i), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o), .trace_rd_addr_o(trace_rd_addr_o),
    .trace_rd_data_o(trace_rd_data_o), .trace_seq_o(trace_seq_o), .count_o(count_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Every accepted handshake must match the oldest expected record
  always @(negedge clk_i) begin
    if (rstn_i && trace_valid_o && trace_ready_i) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_record: got seq %0d pc %h, expected none", trace_seq_o, trace_pc_o);
      end else begin
        logic [116:0] exp_rec;
        logic [116:0] act_rec;
        exp_rec = sb.pop_front();
        act_rec = {trace_pc_o, trace_instr_o, trace_rd_addr_o, trace_rd_data_o, trace_seq_o};
        if (act_rec !== exp_rec) begin
          miscompares++;
          $display("[TB] FAIL record: got pc %h instr %h rd %0d data %h seq %0d, expected pc %h instr %h rd %0d data %h seq %0d",
                   act_rec[116:85], act_rec[84:53], act_rec[52:48], act_rec[47:16], act_rec[15:0],
                   exp_rec[116:85], exp_rec[84:53], exp_rec[52:48], exp_rec[47:16], exp_rec[15:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One commit cycle; accept=0 marks a hand-computed drop
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [4:0] rd, input logic [31:0] data, input bit accept);
    bit captured;
    captured = 1'b1;
`ifdef TRACE_FILTER_NOP_EN
    if (instr == 32'h13 || instr == 32'h0) captured = 1'b0;
`endif
    enable_i   = 1'b1;
    stall_i    = 1'b0;
    pc_i       = pc;
    instr_i    = instr;
    reg_addr_i = rd;
    reg_data_i = data;
    if (captured && accept) sb.push_back({pc, instr, rd, data, seq_model});
    if (captured) seq_model = seq_model + 16'd1;
    tick();
    enable_i = 1'b0;
  endtask

  task automatic pulseReset();
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    sb.delete();
    seq_model = '0;
  endtask

  task automatic drainAll();
    bit done;
    done = 1'b0;
    trace_ready_i = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (sb.size() == 0 && count_o == 5'd0) done = 1'b1;
    end
    trace_ready_i = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d records pending, expected 0", sb.size());
    end
  endtask

  initial begin
    rstn_i = 1'b0; enable_i = 1'b0; clear_i = 1'b0; stall_i = 1'b0;
    pc_i = '0; instr_i = '0; reg_addr_i = '0; reg_data_i = '0; trace_ready_i = 1'b0;
    tick();
    tick();
    rstn_i = 1'b1;
    checkOutput("reset_valid", 32'(trace_valid_o), 32'd0);
    checkOutput("reset_count", 32'(count_o), 32'd0);
    checkOutput("reset_pc", trace_pc_o, 32'd0);
    checkOutput("reset_seq", 32'(trace_seq_o), 32'd0);

    $display("[TB] single push, idle sink");
    applyStimulus(32'h80, 32'h00500093, 5'd1, 32'd5, 1'b1);
    checkOutput("single_valid", 32'(trace_valid_o), 32'd1);
    checkOutput("single_pc", trace_pc_o, 32'h80);
    checkOutput("single_instr", trace_instr_o, 32'h00500093);
    checkOutput("single_rd", 32'(trace_rd_addr_o), 32'd1);
    checkOutput("single_data", trace_rd_data_o, 32'd5);
    checkOutput("single_seq", 32'(trace_seq_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("stable_pc", trace_pc_o, 32'h80);
      checkOutput("stable_valid", 32'(trace_valid_o), 32'd1);
    end
    drainAll();

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) applyStimulus(32'h100 + 32'(i * 4), 32'h00100093, 5'd2, 32'(i), 1'b1);
    pulseReset();
    checkOutput("rst_valid", 32'(trace_valid_o), 32'd0);
    checkOutput("rst_count", 32'(count_o), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt_o), 32'd0);
    checkOutput("rst_overflow", 32'(overflow_o), 32'd0);
    applyStimulus(32'h200, 32'h00200113, 5'd2, 32'h2, 1'b1);
    checkOutput("rst_next_seq", 32'(trace_seq_o), 32'd0);
    drainAll();
    pulseReset();

    $display("[TB] fill and overflow");
    for (int i = 0; i < 18; i++)
      applyStimulus(32'h1000 + 32'(i * 4), 32'h00000093 + 32'(i << 20), 5'(i + 1), 32'hA000 + 32'(i), i < 16);
    checkOutput("fill_count", 32'(count_o), 32'd16);
    checkOutput("fill_drop", 32'(drop_cnt_o), 32'd2);
    checkOutput("fill_overflow", 32'(overflow_o), 32'd1);
    checkOutput("fill_head_seq", 32'(trace_seq_o), 32'd0);

    $display("[TB] full with simultaneous push and pop");
    trace_ready_i = 1'b1;
    applyStimulus(32'h2000, 32'h00300193, 5'd3, 32'hBEEF, 1'b1);
    trace_ready_i = 1'b0;
    checkOutput("fullpp_count", 32'(count_o), 32'd16);
    checkOutput("fullpp_drop", 32'(drop_cnt_o), 32'd2);
    checkOutput("fullpp_head_seq", 32'(trace_seq_o), 32'd1);
    drainAll();

    $display("[TB] stall and clear");
    for (int i = 0; i < 5; i++) begin
      enable_i = 1'b1; stall_i = 1'b1; pc_i = 32'h3000 + 32'(i * 4); instr_i = 32'h00400213;
      tick();
    end
    enable_i = 1'b0; stall_i = 1'b0;
    checkOutput("stall_count", 32'(count_o), 32'd0);
    checkOutput("stall_overflow_held", 32'(overflow_o), 32'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("clear_drop", 32'(drop_cnt_o), 32'd0);
    checkOutput("clear_overflow", 32'(overflow_o), 32'd0);
    applyStimulus(32'h3100, 32'h00500293, 5'd5, 32'h55, 1'b1);
    checkOutput("post_stall_seq", 32'(trace_seq_o), 32'd19);
    drainAll();

    $display("[TB] pointer wrap with continuous ready");
    pulseReset();
    trace_ready_i = 1'b1;
    for (int i = 0; i < 40; i++)
      applyStimulus(32'h4000 + 32'(i * 4), (i % 8 == 3) ? 32'h13 : 32'h00600313 + 32'(i << 7),
                    5'(i), 32'hC000 + 32'(i), 1'b1);
    drainAll();
    checkOutput("wrap_drop", 32'(drop_cnt_o), 32'd0);
    checkOutput("wrap_overflow", 32'(overflow_o), 32'd0);

    $display("[TB] clear coinciding with a drop");
    for (int i = 0; i < 16; i++)
      applyStimulus(32'h5000 + 32'(i * 4), 32'h00700393 + 32'(i << 7), 5'd7, 32'(i), 1'b1);
    clear_i = 1'b1;
    applyStimulus(32'h5100, 32'h00800413, 5'd8, 32'h8, 1'b0);
    clear_i = 1'b0;
    checkOutput("clrdrop_drop", 32'(drop_cnt_o), 32'd1);
    checkOutput("clrdrop_overflow", 32'(overflow_o), 32'd1);
    applyStimulus(32'h5104, 32'h00900493, 5'd9, 32'h9, 1'b0);
    checkOutput("second_drop", 32'(drop_cnt_o), 32'd2);
    checkOutput("second_drop_count", 32'(count_o), 32'd16);
    drainAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
